win_check: RTL and testbench
============================

Name: win_check

Overview:
- Downstream of the cursor/drop stage. Consumes the two per-player occupancy boards and the drop-complete pulse.
- Snapshots the boards when a drop completes, then scans every anchor cell for four-in-a-row of the player who just dropped. Reports win, draw or illegal-board, plus a mask of the winning cells.
- The game-control FSM uses the result to end the game or toggle currentPlayer. The display uses the mask to flash the winning line.

Parameters:
ROWS, 6, board rows; row 0 is the bottom row, row ROWS-1 is the top row
COLS, 7, board columns; col 0 is the leftmost column
CONNECT, 4, line length that counts as a win

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  drop-complete pulse; sampled only in IDLE
currentPlayer  input  1  player who just dropped (0 selects board0, 1 selects board1)
board0  input  [ROWS-1:0][COLS-1:0]  player-0 occupancy, indexed board0[row][col]
board1  input  [ROWS-1:0][COLS-1:0]  player-1 occupancy, same indexing
busy  output  1  high while state is not IDLE
done  output  1  one-cycle pulse when a result is valid
win  output  1  currentPlayer (as snapshotted) has CONNECT in a line
draw  output  1  no win and every cell is occupied
illegal  output  1  some cell is set in both boards
winPlayer  output  1  snapshotted currentPlayer, valid with done
winMask  output  [ROWS-1:0][COLS-1:0]  cells of the first winning line found; all zero if no win

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset: state=IDLE; busy, done, win, draw, illegal, winPlayer = 0; winMask = 0; anchor index = 0.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - start=1 snapshots the selected player's board to snapBoard and board0|board1 to snapOcc.
  - Latches winPlayer=currentPlayer, clears win/draw/illegal/winMask, sets idx=0.
  - If (board0 & board1) != 0: illegal=1, next state REPORT (no scan).
  - Otherwise next state SCAN.
- SCAN:
  - One anchor per cycle, row-major order: idx = row*COLS + col, idx 0..ROWS*COLS-1.
  - Each anchor tests 4 directions on snapBoard: right (col+i), up (row+i), up-right (row+i, col+i), up-left (row+i, col-i), for i = 0..CONNECT-1.
  - A direction whose cells fall off the board evaluates false. There is no wrap-around.
  - Priority within an anchor: right > up > up-right > up-left.
  - On the first hit: win=1, winMask = the CONNECT cells of that line, next state REPORT.
  - No hit and idx = ROWS*COLS-1: draw = (snapOcc all ones), next state REPORT.
  - Otherwise idx++.
- REPORT: done=1 for exactly this cycle, then IDLE. win/draw/illegal/winMask/winPlayer hold until the next accepted start.
- Latency, with start sampled at edge n:
  - Hit at anchor k: done is high in the cycle after edge n+k+1, i.e. k+2 cycles after start.
  - No win: ROWS*COLS+1 = 43 cycles.
  - Illegal: 1 cycle.
- start while busy is ignored; there is no queueing. Input boards may change during the scan; only the snapshot is used.
- win and draw are mutually exclusive. illegal forces win=0 and draw=0.
- Reset mid-SCAN returns to IDLE with all outputs 0. No done is generated.
- busy = (state != IDLE). busy is high during REPORT.

Decomposition:
- Package connect4_pkg: ROWS, COLS, CONNECT constants; typedef board_t = logic [ROWS-1:0][COLS-1:0]; typedef enum state_t {IDLE, SCAN, REPORT}. The drop stage adopts board_t.
- Sub-module line_match, purely combinational:
  - Inputs: board_t, anchor row/col.
  - Outputs: hit, board_t mask.
  - Contains the 4-direction evaluation, bounds checks and priority.
- win_check holds the FSM, snapshot registers, index counter and output registers.

Test Plan:
- Horizontal: board0 row 0 cols 0-3 set, board1 = 0, currentPlayer=0, start pulse -> done 2 cycles after start (k=0); win=1; winMask row0 = 7'b0001111; draw=0; illegal=0.
- Vertical, late anchor: board1 col 6 rows 2-5 set, currentPlayer=1 -> hit at k=20 (row 2, col 6); done 22 cycles after start; winMask marks col 6 rows 2-5; winPlayer=1.
- Up-left diagonal: board0 cells (0,3), (1,2), (2,1), (3,0) set -> hit at anchor (0,3), k=3; done 5 cycles after start; winMask marks exactly those 4 cells.
- Wrong player / draw:
  - board0 has a horizontal four but currentPlayer=1 and board1 has no line -> done after 43 cycles; win=0; draw=0.
  - Full board, boards disjoint, no line for currentPlayer -> done after 43 cycles; draw=1.
- Illegal: board0[0][0] = board1[0][0] = 1 -> done 1 cycle after start; illegal=1; win=0; draw=0.
- Control:
  - Second start pulse at cycle 5 of a scan -> ignored; exactly one done.
  - reset at cycle 10 of a scan -> next cycle busy=0, outputs 0, no done.
  - Board inputs changed mid-scan -> result matches the snapshot.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 board geometry, board type and win-check states.
// Imported by the drop stage and by win_check.
package connect4_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int CONNECT = 4;
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/line_match.sv
// Four-direction line test from one anchor cell.
// Right beats up, up beats up-right, up-right beats up-left.
module line_match
    import connect4_pkg::*;
(
    input  board_t        board,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    output logic          hit,
    output board_t        mask
);

    // Any step that leaves the board fails the whole line; no wrap.
    function automatic logic probe(
        input  board_t b,
        input  int     r,
        input  int     c,
        input  int     dr,
        input  int     dc,
        output board_t m
    );
        int   rr;
        int   cc;
        logic ok;
        ok = 1'b1;
        m  = '0;
        for (int i = 0; i < CONNECT; i++) begin
            rr = r + i * dr;
            cc = c + i * dc;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                ok = 1'b0;
            end else begin
                ok = ok & b[RW'(rr)][CW'(cc)];
                m[RW'(rr)][CW'(cc)] = 1'b1;
            end
        end
        return ok;
    endfunction

    int     r;
    int     c;
    logic   hr;
    logic   hu;
    logic   hur;
    logic   hul;
    board_t mr;
    board_t mu;
    board_t mur;
    board_t mul;

    always_comb begin
        r    = int'(row);
        c    = int'(col);
        hr   = probe(board, r, c, 0, 1, mr);
        hu   = probe(board, r, c, 1, 0, mu);
        hur  = probe(board, r, c, 1, 1, mur);
        hul  = probe(board, r, c, 1, -1, mul);
        hit  = 1'b0;
        mask = '0;
        if (hr) begin
            hit  = 1'b1;
            mask = mr;
        end else if (hu) begin
            hit  = 1'b1;
            mask = mu;
        end else if (hur) begin
            hit  = 1'b1;
            mask = mur;
        end else if (hul) begin
            hit  = 1'b1;
            mask = mul;
        end
    end

endmodule

// File: rtl/win_check.sv
// Snapshots both boards on drop-complete and scans one anchor per
// cycle for a win by the dropping player; reports win/draw/illegal.
module win_check
    import connect4_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   currentPlayer,
    input  board_t board0,
    input  board_t board1,
    output logic   busy,
    output logic   done,
    output logic   win,
    output logic   draw,
    output logic   illegal,
    output logic   winPlayer,
    output board_t winMask
);

    state_t        state;
    state_t        state_nx;
    board_t        snap_board;
    board_t        snap_occ;
    board_t        line_mask;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          hit;
    logic          last;
    logic          clash;

    line_match u_match (
        .board (snap_board),
        .row   (row),
        .col   (col),
        .hit   (hit),
        .mask  (line_mask)
    );

    assign clash = |(board0 & board1);
    assign last  = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));
    assign busy  = (state != IDLE);
    assign done  = (state == REPORT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = clash ? REPORT : SCAN;
            SCAN:    if (hit || last) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_board <= '0;
            snap_occ   <= '0;
            row        <= '0;
            col        <= '0;
            win        <= 1'b0;
            draw       <= 1'b0;
            illegal    <= 1'b0;
            winPlayer  <= 1'b0;
            winMask    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap_board <= currentPlayer ? board1 : board0;
                        snap_occ   <= board0 | board1;
                        winPlayer  <= currentPlayer;
                        win        <= 1'b0;
                        draw       <= 1'b0;
                        illegal    <= clash;
                        winMask    <= '0;
                        row        <= '0;
                        col        <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        win     <= 1'b1;
                        winMask <= line_mask;
                    end else if (last) begin
                        draw <= &snap_occ;
                    end else if (col == CW'(COLS - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_win_check.sv
// Directed bench for win_check: latency, result flags, masks,
// ignored restart, mid-scan reset and mid-scan board changes.
module tb_win_check;
    import connect4_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   start;
    logic   currentPlayer;
    board_t board0;
    board_t board1;
    logic   busy;
    logic   done;
    logic   win;
    logic   draw;
    logic   illegal;
    logic   winPlayer;
    board_t winMask;

    int n_vec = 0;
    int n_bad = 0;

    win_check dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .currentPlayer (currentPlayer),
        .board0        (board0),
        .board1        (board1),
        .busy          (busy),
        .done          (done),
        .win           (win),
        .draw          (draw),
        .illegal       (illegal),
        .winPlayer     (winPlayer),
        .winMask       (winMask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic res(input string tag, input logic w, input logic d,
                       input logic il, input logic wp, input board_t m);
        check({tag, ".win"}, 64'(win), 64'(w));
        check({tag, ".draw"}, 64'(draw), 64'(d));
        check({tag, ".illegal"}, 64'(illegal), 64'(il));
        check({tag, ".winPlayer"}, 64'(winPlayer), 64'(wp));
        check({tag, ".winMask"}, 64'(winMask), 64'(m));
        check({tag, ".busy"}, 64'(busy), 64'(0));
    endtask

    // xs: extra start cycle, rs: reset cycle, ch: board-change cycle
    task automatic run(input string tag, input board_t b0,
                       input board_t b1, input logic cp,
                       input int xs, input int rs, input int ch,
                       input int exp_lat, input int exp_n);
        int lat;
        int nd;
        lat = -1;
        nd  = 0;
        @(negedge clk);
        board0        = b0;
        board1        = b1;
        currentPlayer = cp;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (done) begin
                nd++;
                if (lat < 0) lat = c;
            end
            start = (c == xs);
            reset = (c == rs);
            if (c == ch) begin
                board0 = '0;
                board1 = '1;
            end
            @(posedge clk);
            #1;
            if (c == rs) begin
                check({tag, ".rst_busy"}, 64'(busy), 64'(0));
                check({tag, ".rst_done"}, 64'(done), 64'(0));
                check({tag, ".rst_win"}, 64'(win), 64'(0));
                check({tag, ".rst_mask"}, 64'(winMask), 64'(0));
            end
        end
        start = 1'b0;
        reset = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".ndone"}, 64'(nd), 64'(exp_n));
    endtask

    board_t e;
    board_t h0;
    board_t v1;
    board_t ul;
    board_t wp1;
    board_t f0;
    board_t il0;

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        currentPlayer = 1'b0;
        board0        = '0;
        board1        = '0;
        e             = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.done", 64'(done), 64'(0));
        res("rst", 1'b0, 1'b0, 1'b0, 1'b0, e);
        reset = 1'b0;

        h0       = '0;
        h0[0]    = 7'b0001111;
        run("horiz", h0, e, 1'b0, 0, 0, 0, 2, 1);
        res("horiz", 1'b1, 1'b0, 1'b0, 1'b0, h0);

        v1 = '0;
        for (int r = 2; r <= 5; r++) v1[r][6] = 1'b1;
        run("vert", e, v1, 1'b1, 0, 0, 0, 22, 1);
        res("vert", 1'b1, 1'b0, 1'b0, 1'b1, v1);

        ul       = '0;
        ul[0][3] = 1'b1;
        ul[1][2] = 1'b1;
        ul[2][1] = 1'b1;
        ul[3][0] = 1'b1;
        run("upleft", ul, e, 1'b0, 0, 0, 0, 5, 1);
        res("upleft", 1'b1, 1'b0, 1'b0, 1'b0, ul);

        wp1       = '0;
        wp1[1][0] = 1'b1;
        run("wrongp", h0, wp1, 1'b1, 0, 0, 0, 43, 1);
        res("wrongp", 1'b0, 1'b0, 1'b0, 1'b1, e);

        // Column pairs alternating by row: no four anywhere for either side
        f0 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f0[r][c] = (((c / 2) + r) % 2) == 1;
        run("draw", f0, ~f0, 1'b0, 0, 0, 0, 43, 1);
        res("draw", 1'b0, 1'b1, 1'b0, 1'b0, e);

        il0       = '0;
        il0[0][0] = 1'b1;
        run("illegal", il0, il0, 1'b0, 0, 0, 0, 1, 1);
        res("illegal", 1'b0, 1'b0, 1'b1, 1'b0, e);

        run("restart", e, v1, 1'b1, 5, 0, 0, 22, 1);
        res("restart", 1'b1, 1'b0, 1'b0, 1'b1, v1);

        run("change", e, v1, 1'b1, 0, 0, 3, 22, 1);
        res("change", 1'b1, 1'b0, 1'b0, 1'b1, v1);

        run("midrst", e, v1, 1'b1, 0, 10, 0, -1, 0);
        res("midrst", 1'b0, 1'b0, 1'b0, 1'b0, e);

        run("after", h0, e, 1'b0, 0, 0, 0, 2, 1);
        res("after", 1'b1, 1'b0, 1'b0, 1'b0, h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
